// File: rtl/wide_add_seq.sv
// wide_add_seq: W-bit add/subtract built from one 16-bit adder slice that is
// reused once per clock, least-significant slice first. A request is accepted
// in IDLE, the slices are walked in RUN, and the result is held in DONE until
// the consumer takes it. flush aborts RUN/DONE back to IDLE.
module wide_add_seq #(
  parameter int NSLICE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [16*NSLICE-1:0]   op_a,
  input  logic [16*NSLICE-1:0]   op_b,
  input  logic                   op_sub,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [16*NSLICE-1:0]   result,
  output logic                   cout,
  output logic                   ovf,
  output logic                   zero
);

  localparam int W  = 16 * NSLICE;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [KW-1:0]   k_q;
  logic            carry_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;      // already inverted for subtract
  logic [W-1:0]    result_q;
  logic            cout_q;
  logic            ovf_q;
  logic            zero_q;
  logic            out_valid_q;
  logic            in_ready_q;

  logic [15:0]     slice_a;
  logic [15:0]     slice_b;
  logic [15:0]     slice_sum;
  logic            slice_cout;
  logic            slice_c15;  // carry into bit 15 of the slice
  logic [W-1:0]    result_d;
  logic            last_slice;

  // The single 16-bit adder slice, fed from slice k of the latched operands.
  always_comb begin
    slice_a                 = a_q[16*int'(k_q) +: 16];
    slice_b                 = b_q[16*int'(k_q) +: 16];
    {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {16'h0000, carry_q};
    // sum = a ^ b ^ cin bitwise, so the carry into the MSB can be recovered
    slice_c15               = slice_sum[15] ^ slice_a[15] ^ slice_b[15];
    result_d                = result_q;
    result_d[16*int'(k_q) +: 16] = slice_sum;
    last_slice              = (k_q == KW'(NSLICE - 1));
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= KW'(0);
      carry_q     <= 1'b0;
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      result_q    <= {W{1'b0}};
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          // flush in IDLE only blocks a same-cycle accept
          if (in_valid && !flush) begin
            a_q         <= op_a;
            b_q         <= op_sub ? ~op_b : op_b;
            carry_q     <= op_sub;
            k_q         <= KW'(0);
            in_ready_q  <= 1'b0;
            state_q     <= S_RUN;
          end else begin
            in_ready_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (flush) begin
            k_q         <= KW'(0);
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            result_q <= result_d;
            carry_q  <= slice_cout;
            if (last_slice) begin
              k_q         <= KW'(0);
              cout_q      <= slice_cout;
              ovf_q       <= slice_c15 ^ slice_cout;
              zero_q      <= (result_d == {W{1'b0}});
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              k_q         <= k_q + KW'(1);
            end
          end
        end
        S_DONE: begin
          // flush and handshake both end in IDLE; results stay frozen otherwise
          if (flush || out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          k_q         <= KW'(0);
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed self-checking bench for wide_add_seq (NSLICE=4, W=64).
module tb_wide_add_seq;

  localparam int NSLICE = 4;
  localparam int W      = 16 * NSLICE;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           op_sub;
  logic           flush;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   result;
  logic           cout;
  logic           ovf;
  logic           zero;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;  // cycle index after the accept edge (1 = first RUN cycle)

  wide_add_seq #(.NSLICE(NSLICE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present a request and let the accept edge pass.
  task automatic do_accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    op_a     = a;
    op_b     = b;
    op_sub   = sub;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc      = 1;
  endtask

  // Wait (bounded) for out_valid and compare latency plus all result fields.
  task automatic wait_result(input string tag, input logic [W-1:0] er, input logic ec,
                             input logic eo, input logic ez);
    while (!out_valid && cyc < 30) step();
    check_eq({tag, "_lat"},   64'(cyc), 64'(NSLICE + 1));
    check_eq({tag, "_vld"},   64'(out_valid), 64'd1);
    check_eq({tag, "_res"},   result, er);
    check_eq({tag, "_cout"},  64'(cout), 64'(ec));
    check_eq({tag, "_ovf"},   64'(ovf), 64'(eo));
    check_eq({tag, "_zero"},  64'(zero), 64'(ez));
    check_eq({tag, "_rdy"},   64'(in_ready), 64'd0);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq({tag, "_rel_vld"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_rel_rdy"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = 64'h0;
    op_b      = 64'h0;
    op_sub    = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #12;
    check_eq("rst_vld",  64'(out_valid), 64'd0);
    check_eq("rst_rdy",  64'(in_ready), 64'd1);
    check_eq("rst_res",  result, 64'h0);
    check_eq("rst_flags", {61'd0, cout, ovf, zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Carry across a slice boundary
    do_accept(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    wait_result("add_carry", 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
    release_result("add_carry");

    do_accept(64'h5, 64'h5, 1'b1);
    wait_result("sub_zero", 64'h0, 1'b1, 1'b0, 1'b1);
    release_result("sub_zero");

    do_accept(64'h0, 64'h1, 1'b1);
    wait_result("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    release_result("sub_borrow");

    do_accept(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0);
    wait_result("add_ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    release_result("add_ovf");

    do_accept(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    wait_result("add_wrap", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0);
    release_result("add_wrap");

    do_accept(64'h8000_0000_0000_0000, 64'h1, 1'b1);
    wait_result("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    release_result("sub_ovf");

    // out_ready pulsed during RUN must not disturb the operation
    do_accept(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    wait_result("mixed", 64'h2345_6789_ABCD_F001, 1'b0, 1'b0, 1'b0);
    release_result("mixed");

    // Backpressure: DONE held with a competing request on the input
    do_accept(64'h3, 64'h4, 1'b0);
    wait_result("bp", 64'h7, 1'b0, 1'b0, 1'b0);
    op_a     = 64'h100;
    op_b     = 64'h200;
    op_sub   = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("bp_hold_vld", 64'(out_valid), 64'd1);
      check_eq("bp_hold_res", result, 64'h7);
      check_eq("bp_hold_rdy", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("bp_idle_vld", 64'(out_valid), 64'd0);
    check_eq("bp_idle_rdy", 64'(in_ready), 64'd1);
    do_accept(64'h100, 64'h200, 1'b0);
    wait_result("bp_new", 64'h300, 1'b0, 1'b0, 1'b0);
    release_result("bp_new");

    // flush during RUN slice 2
    do_accept(64'h1, 64'h1, 1'b0);
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush_run_rdy", 64'(in_ready), 64'd1);
    check_eq("flush_run_vld", 64'(out_valid), 64'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq("flush_run_never", 64'(out_valid), 64'd0);
    end

    // flush in DONE drops the result
    do_accept(64'h2, 64'h3, 1'b0);
    wait_result("flush_done", 64'h5, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush_done_vld", 64'(out_valid), 64'd0);
    check_eq("flush_done_rdy", 64'(in_ready), 64'd1);

    // Asynchronous reset in RUN slice 1
    do_accept(64'h0000_0000_0000_0009, 64'h0000_0000_0000_0001, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_res",   result, 64'h0);
    check_eq("arst_flags", {61'd0, cout, ovf, zero}, 64'd0);
    check_eq("arst_vld",   64'(out_valid), 64'd0);
    check_eq("arst_rdy",   64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    // First rising edge after reset release must accept
    do_accept(64'hA, 64'h3, 1'b1);
    wait_result("post_rst", 64'h7, 1'b1, 1'b0, 1'b0);
    release_result("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
